shift_sin_pout_n: RTL and testbench
===================================

Name: shift_sin_pout_n

Overview:
Parametrised serial-in/parallel-out deserialiser for the TIPI link. It is the successor of the fixed 8-bit shifter.
- Adds configurable width, bit order and auto-latch on word completion.
- Adds a bit counter, a valid/ack output handshake, and sticky framing and overrun flags.
- Sits between the TIPI serial data/strobe pins and the register file that the 99/4A-side logic reads.

Parameters:
WIDTH, 8, word length in bits (2..32)
MSB_FIRST, 1, 1 = new bit enters at bit 0 and shifts toward the MSB; 0 = new bit enters at bit WIDTH-1 and shifts toward bit 0
AUTO_LATCH, 0, 1 = transfer to the output latch automatically when the WIDTH-th bit is shifted in
ODD_PARITY, 0, 1 = parity outputs are inverted (odd parity)

Ports:
clk  in  1  system clock, all state updates on rising edge
reset  in  1  synchronous active-high reset
select  in  1  enables shift/latch operations; when low, shift state holds
le  in  1  latch enable (qualified by select): copy shifter to output latch
din  in  1  serial data bit (qualified by select & !le)
dout_ack  in  1  consumer acknowledges dout; not qualified by select
err_clr  in  1  clears the frame_err and overrun sticky flags
dout  out  WIDTH  latched parallel word
dout_valid  out  1  latched word not yet acknowledged
dout_parity  out  1  parity of dout, captured at latch time
parity  out  1  live parity of the shifter: ^shift_q ^ ODD_PARITY
bit_count  out  $clog2(WIDTH+1)  bits shifted since the last latch
frame_err  out  1  sticky: latch happened at a non-word boundary
overrun  out  1  sticky: latch overwrote an unacknowledged word

Behaviour:
- Reset (synchronous, highest priority): shift_q=0, dout=0, bit_count=0, dout_valid=0, dout_parity=ODD_PARITY, frame_err=0, overrun=0. parity then reads ODD_PARITY.
- select=0: shift_q and bit_count hold. dout_ack and err_clr still act.
- Shift (select & !le), one bit per cycle:
  - MSB_FIRST=1: shift_q <= {shift_q[W-2:0], din}.
  - MSB_FIRST=0: shift_q <= {din, shift_q[W-1:1]}.
  - bit_count increments and saturates at WIDTH.
- Auto-latch (AUTO_LATCH=1, shift with bit_count==WIDTH-1):
  - The same edge loads dout with the new shift value, including the incoming bit.
  - bit_count <= 0 and latch event = 1.
  - No added latency: dout and dout_valid are updated on the edge of the last bit.
- Manual latch (select & le):
  - dout <= shift_q, bit_count <= 0, latch event = 1.
  - No shift occurs that cycle; shift_q itself is kept.
  - Boundary: frame_err is set if bit_count != WIDTH when AUTO_LATCH=0, or if bit_count != 0 when AUTO_LATCH=1. The data is latched anyway.
- A latch event sets dout_parity <= ^(latched word) ^ ODD_PARITY.
- Handshake:
  - dout_valid <= 1 on a latch event.
  - Otherwise dout_ack clears dout_valid.
  - dout_ack while dout_valid=0 is ignored.
- Overrun:
  - Set when a latch event occurs with dout_valid=1 and dout_ack=0 in the same cycle. The data is overwritten.
  - Latch with a simultaneous ack: dout_valid stays 1 and no overrun.
- Sticky flags:
  - err_clr clears frame_err and overrun.
  - If a set condition and err_clr coincide, set wins.
- bit_count saturation: in manual mode, extra shifts beyond WIDTH keep shifting and discard the oldest bit. bit_count stays WIDTH.
- Reset mid-word discards partial bits. No output glitches; all outputs are registered except parity.

Decomposition:
- Package tipi_pkg: width-derived constant CNT_W = $clog2(WIDTH+1) as a localparam function, and bit-order constants MSB_FIRST/LSB_FIRST.
- One natural sub-module: sipo_status, which holds the valid/overrun/frame_err handshake logic. It takes a latch_evt and boundary_ok, so the datapath stays a pure shifter plus counter.

Test Plan:
1. WIDTH=8, MSB_FIRST=1, AUTO_LATCH=0: shift 1,0,1,0,0,1,0,1, then le -> dout=0xA5, dout_valid=1, dout_parity=0, frame_err=0, bit_count=0.
2. MSB_FIRST=0, AUTO_LATCH=1: shift 1,0,1,0,0,1,0,1 -> on the 8th-bit edge dout=0xA5 (LSB-first reconstruct) and dout_valid=1 with no le. Next cycle bit_count=1 after a further shift.
3. Overrun: two auto-latched words with no dout_ack -> overrun=1, dout=second word. Repeat with dout_ack asserted on the second latch edge -> overrun stays 0, dout_valid=1.
4. Framing: AUTO_LATCH=0, 5 bits then le -> frame_err=1, dout = the 5 bits right-aligned. err_clr -> frame_err=0. err_clr coincident with a new bad le -> frame_err=1.
5. select=0 for 3 cycles mid-word with din toggling -> shift_q and bit_count unchanged. dout_ack still clears dout_valid.
6. Assert reset after 4 bits of a word -> all outputs at reset values next edge (parity=ODD_PARITY). Then 8 bits plus le yields the clean word 0x3C with no frame_err.

Source files
------------

// File: rtl/tipi_pkg.sv
// rtl/tipi_pkg.sv - shared constants and width helpers for the TIPI deserialiser
package tipi_pkg;

  localparam bit BIT_MSB_FIRST = 1'b1;
  localparam bit BIT_LSB_FIRST = 1'b0;

  // Counter width able to hold 0..width inclusive
  function automatic int cnt_w(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/sipo_status.sv
// rtl/sipo_status.sv - output handshake plus sticky overrun and framing flags
module sipo_status (
  input  logic clk,
  input  logic reset,
  input  logic latch_evt,
  input  logic boundary_ok,
  input  logic dout_ack,
  input  logic err_clr,
  output logic dout_valid,
  output logic overrun,
  output logic frame_err
);

  always_ff @(posedge clk) begin
    if (reset) begin
      dout_valid <= 1'b0;
      overrun    <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      if (latch_evt) begin
        dout_valid <= 1'b1;
      end else if (dout_ack) begin
        dout_valid <= 1'b0;
      end

      // A new set condition beats a coincident clear
      if (latch_evt && dout_valid && !dout_ack) begin
        overrun <= 1'b1;
      end else if (err_clr) begin
        overrun <= 1'b0;
      end

      if (latch_evt && !boundary_ok) begin
        frame_err <= 1'b1;
      end else if (err_clr) begin
        frame_err <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/shift_sin_pout_n.sv
// rtl/shift_sin_pout_n.sv - serial-in/parallel-out deserialiser with output latch
module shift_sin_pout_n
  import tipi_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter bit MSB_FIRST  = BIT_MSB_FIRST,
  parameter bit AUTO_LATCH = 1'b0,
  parameter bit ODD_PARITY = 1'b0,
  localparam int CNT_W     = cnt_w(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             select,
  input  logic             le,
  input  logic             din,
  input  logic             dout_ack,
  input  logic             err_clr,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  output logic             dout_parity,
  output logic             parity,
  output logic [CNT_W-1:0] bit_count,
  output logic             frame_err,
  output logic             overrun
);

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  logic [WIDTH-1:0] shift_q;
  logic [WIDTH-1:0] shift_next;
  logic [WIDTH-1:0] latch_word;
  logic             shift_en;
  logic             man_latch;
  logic             auto_latch;
  logic             latch_evt;
  logic             boundary_ok;

  always_comb begin
    shift_next  = MSB_FIRST ? {shift_q[WIDTH-2:0], din} : {din, shift_q[WIDTH-1:1]};
    shift_en    = select & ~le;
    man_latch   = select & le;
    auto_latch  = AUTO_LATCH && shift_en && (bit_count == CNT_LAST);
    latch_evt   = man_latch | auto_latch;
    // Auto-latch captures the word including the bit arriving this edge
    latch_word  = auto_latch ? shift_next : shift_q;
    boundary_ok = auto_latch ? 1'b1
                : (AUTO_LATCH ? (bit_count == '0) : (bit_count == CNT_FULL));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      shift_q     <= '0;
      bit_count   <= '0;
      dout        <= '0;
      dout_parity <= ODD_PARITY;
    end else begin
      if (shift_en) begin
        shift_q <= shift_next;
      end
      if (latch_evt) begin
        bit_count   <= '0;
        dout        <= latch_word;
        dout_parity <= (^latch_word) ^ ODD_PARITY;
      end else if (shift_en && (bit_count != CNT_FULL)) begin
        bit_count <= bit_count + 1'b1;
      end
    end
  end

  assign parity = (^shift_q) ^ ODD_PARITY;

  sipo_status u_status (
    .clk         (clk),
    .reset       (reset),
    .latch_evt   (latch_evt),
    .boundary_ok (boundary_ok),
    .dout_ack    (dout_ack),
    .err_clr     (err_clr),
    .dout_valid  (dout_valid),
    .overrun     (overrun),
    .frame_err   (frame_err)
  );

endmodule

// File: tb/tb_shift_sin_pout_n.sv
// tb/tb_shift_sin_pout_n.sv - bench for shift_sin_pout_n in two configurations
module tb_shift_sin_pout_n;

  localparam int W = 8;

  logic clk;
  logic reset, select, le, din, dout_ack, err_clr;

  logic [W-1:0] o_dout  [2];
  logic         o_valid [2];
  logic         o_dpar  [2];
  logic         o_par   [2];
  logic [3:0]   o_cnt   [2];
  logic         o_ferr  [2];
  logic         o_ovr   [2];

  int checks = 0;
  int errors = 0;

  // Instance 0: MSB-first, manual latch, even parity
  shift_sin_pout_n #(.WIDTH(W), .MSB_FIRST(1'b1), .AUTO_LATCH(1'b0), .ODD_PARITY(1'b0)) dut_m (
    .clk(clk), .reset(reset), .select(select), .le(le), .din(din),
    .dout_ack(dout_ack), .err_clr(err_clr),
    .dout(o_dout[0]), .dout_valid(o_valid[0]), .dout_parity(o_dpar[0]),
    .parity(o_par[0]), .bit_count(o_cnt[0]), .frame_err(o_ferr[0]), .overrun(o_ovr[0])
  );

  // Instance 1: LSB-first, auto latch, odd parity
  shift_sin_pout_n #(.WIDTH(W), .MSB_FIRST(1'b0), .AUTO_LATCH(1'b1), .ODD_PARITY(1'b1)) dut_l (
    .clk(clk), .reset(reset), .select(select), .le(le), .din(din),
    .dout_ack(dout_ack), .err_clr(err_clr),
    .dout(o_dout[1]), .dout_valid(o_valid[1]), .dout_parity(o_dpar[1]),
    .parity(o_par[1]), .bit_count(o_cnt[1]), .frame_err(o_ferr[1]), .overrun(o_ovr[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: arrival history of the last W bits (oldest first) plus per-instance state
  bit           hist [$];
  int           m_cnt   [2];
  logic [W-1:0] m_dout  [2];
  bit           m_valid [2];
  bit           m_dpar  [2];
  bit           m_ferr  [2];
  bit           m_ovr   [2];

  function automatic bit cfg_msb(input int c);  return c == 0; endfunction
  function automatic bit cfg_auto(input int c); return c == 1; endfunction
  function automatic bit cfg_odd(input int c);  return c == 1; endfunction

  // MSB-first: newest bit lands at bit 0; LSB-first: newest bit lands at bit W-1
  function automatic logic [W-1:0] word_of(input int c);
    logic [W-1:0] w;
    for (int j = 0; j < W; j++) w[j] = cfg_msb(c) ? hist[W-1-j] : hist[j];
    return w;
  endfunction

  task automatic model_reset();
    hist = {};
    repeat (W) hist.push_back(1'b0);
    for (int c = 0; c < 2; c++) begin
      m_cnt[c] = 0; m_dout[c] = '0; m_valid[c] = 0;
      m_dpar[c] = cfg_odd(c); m_ferr[c] = 0; m_ovr[c] = 0;
    end
  endtask

  task automatic model_step();
    bit latch, ok, set_ovr, set_fe;
    logic [W-1:0] word;
    if (reset) begin
      model_reset();
      return;
    end
    if (select && !le) begin
      hist.push_back(din);
      void'(hist.pop_front());
    end
    for (int c = 0; c < 2; c++) begin
      latch = 0; ok = 1; word = '0;
      if (select && !le) begin
        if (cfg_auto(c) && m_cnt[c] + 1 == W) begin
          latch = 1; word = word_of(c); m_cnt[c] = 0;
        end else if (m_cnt[c] < W) begin
          m_cnt[c]++;
        end
      end else if (select && le) begin
        latch = 1; word = word_of(c);
        ok = cfg_auto(c) ? (m_cnt[c] == 0) : (m_cnt[c] == W);
        m_cnt[c] = 0;
      end
      set_ovr = latch && m_valid[c] && !dout_ack;
      set_fe  = latch && !ok;
      if (latch) begin
        m_valid[c] = 1; m_dout[c] = word; m_dpar[c] = (^word) ^ cfg_odd(c);
      end else if (dout_ack) begin
        m_valid[c] = 0;
      end
      m_ovr[c]  = set_ovr ? 1'b1 : (err_clr ? 1'b0 : m_ovr[c]);
      m_ferr[c] = set_fe  ? 1'b1 : (err_clr ? 1'b0 : m_ferr[c]);
    end
  endtask

  task automatic chk(input string tag, input int c, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s[%0d] observed=%0h expected=%0h", tag, c, obs, exp);
    end
  endtask

  task automatic compare_all();
    for (int c = 0; c < 2; c++) begin
      chk("dout",        c, 32'(o_dout[c]),  32'(m_dout[c]));
      chk("dout_valid",  c, 32'(o_valid[c]), 32'(m_valid[c]));
      chk("dout_parity", c, 32'(o_dpar[c]),  32'(m_dpar[c]));
      chk("parity",      c, 32'(o_par[c]),   32'((^word_of(c)) ^ cfg_odd(c)));
      chk("bit_count",   c, 32'(o_cnt[c]),   32'(m_cnt[c]));
      chk("frame_err",   c, 32'(o_ferr[c]),  32'(m_ferr[c]));
      chk("overrun",     c, 32'(o_ovr[c]),   32'(m_ovr[c]));
    end
  endtask

  task automatic step(input logic s, input logic l, input logic d,
                      input logic a, input logic e, input logic r);
    select = s; le = l; din = d; dout_ack = a; err_clr = e; reset = r;
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic shift(input logic d);
    step(1'b1, 1'b0, d, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic shift_msb(input logic [W-1:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) shift(v[i]);
  endtask

  task automatic shift_lsb(input logic [W-1:0] v, input int n);
    for (int i = 0; i < n; i++) shift(v[i]);
  endtask

  logic [W-1:0] w1, w2, v5;

  initial begin
    model_reset();
    select = 0; le = 0; din = 0; dout_ack = 0; err_clr = 0; reset = 1;
    #2;

    // Reset state
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("rst_dout", 0, 32'(o_dout[0]), 32'h0);
    chk("rst_par",  0, 32'(o_par[0]),  32'h0);
    chk("rst_par",  1, 32'(o_par[1]),  32'h1);
    chk("rst_dpar", 1, 32'(o_dpar[1]), 32'h1);

    // A5 in both bit orders; instance 1 auto-latches on the 8th edge
    shift_msb(8'hA5, W);
    chk("auto_dout",  1, 32'(o_dout[1]),  32'hA5);
    chk("auto_valid", 1, 32'(o_valid[1]), 32'h1);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("le_dout",  0, 32'(o_dout[0]),  32'hA5);
    chk("le_valid", 0, 32'(o_valid[0]), 32'h1);
    chk("le_dpar",  0, 32'(o_dpar[0]),  32'h0);
    chk("le_ferr",  0, 32'(o_ferr[0]),  32'h0);
    chk("le_cnt",   0, 32'(o_cnt[0]),   32'h0);
    shift(1'b1);
    chk("after_cnt", 1, 32'(o_cnt[1]), 32'h1);

    // Overrun: two auto words without ack, then with ack on the second latch edge
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    w1 = W'($urandom); w2 = W'($urandom);
    shift_lsb(w1, W);
    shift_lsb(w2, W);
    chk("ovr_set",  1, 32'(o_ovr[1]),  32'h1);
    chk("ovr_dout", 1, 32'(o_dout[1]), 32'(w2));
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    shift_lsb(w1, W);
    shift_lsb(w2, W - 1);
    step(1'b1, 1'b0, w2[W-1], 1'b1, 1'b0, 1'b0);
    chk("ack_ovr",   1, 32'(o_ovr[1]),   32'h0);
    chk("ack_valid", 1, 32'(o_valid[1]), 32'h1);
    chk("ack_dout",  1, 32'(o_dout[1]),  32'(w2));

    // Framing: short word, clear, clear coincident with a bad latch
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    v5 = W'($urandom_range(0, 31));
    shift_msb(v5, 5);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("fe_set",  0, 32'(o_ferr[0]), 32'h1);
    chk("fe_dout", 0, 32'(o_dout[0]), 32'(v5));
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("fe_clr", 0, 32'(o_ferr[0]), 32'h0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("fe_win", 0, 32'(o_ferr[0]), 32'h1);

    // Deselected hold while din toggles; ack still works
    shift_msb(8'h05, 3);
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("hold_cnt",   0, 32'(o_cnt[0]),   32'h3);
    chk("hold_valid", 0, 32'(o_valid[0]), 32'h0);

    // Reset mid-word, then a clean 0x3C
    shift_msb(8'h0F, 4);
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("mid_rst_cnt",   0, 32'(o_cnt[0]),   32'h0);
    chk("mid_rst_valid", 0, 32'(o_valid[0]), 32'h0);
    chk("mid_rst_par",   1, 32'(o_par[1]),   32'h1);
    shift_msb(8'h3C, W);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("clean_dout", 0, 32'(o_dout[0]), 32'h3C);
    chk("clean_ferr", 0, 32'(o_ferr[0]), 32'h0);

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      step(($urandom % 8) != 0, ($urandom % 10) == 0, 1'($urandom),
           ($urandom % 4) == 0, ($urandom % 8) == 0, ($urandom % 50) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
